spi_ram_arbiter: RTL

Round-robin arbiter and transaction sequencer that shares the single-port RAM between two command requesters: the SPI slave path (requester 0) and a local host/test port (requester 1). It sits between the requesters and the RAM command interface. It accepts 10-bit RAM command words (bits [9:8] = opcode: 00 write-address, 01 write-data, 10 read-address, 11 read-data). It locks the RAM to one requester for a complete transaction and routes the 8-bit read response back to the owning requester.

---
 rtl/spi_ram_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/spi_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_ram_arbiter
// Purpose  : Round-robin RAM command arbiter with transaction locking and
//            read-data routing for two requesters (SPI slave, host port).
//            Optional watchdog enabled by defining RAM_ARB_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spi_ram_arbiter #(
  parameter int CMD_W  = 10,
  parameter int DATA_W = 8,
  parameter int TMO_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CMD_W-1:0]  req0_cmd,
  input  logic              req0_valid,
  output logic              req0_ready,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_rvalid,
  input  logic [CMD_W-1:0]  req1_cmd,
  input  logic              req1_valid,
  output logic              req1_ready,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_rvalid,
  output logic [CMD_W-1:0]  ram_din,
  output logic              ram_rx_valid,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic              ram_tx_valid,
  output logic              owner,
  output logic              busy,
  output logic              err
);

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_locked  = 2'd1;
  localparam logic [1:0] c_st_wait_rd = 2'd2;

  localparam logic [1:0] c_op_wr_addr = 2'b00;
  localparam logic [1:0] c_op_wr_data = 2'b01;
  localparam logic [1:0] c_op_rd_addr = 2'b10;
  localparam logic [1:0] c_op_rd_data = 2'b11;

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic              r_owner;
  logic              r_last_grant;
  logic [CMD_W-1:0]  r_ram_din;
  logic              r_ram_rx_valid;
  logic [DATA_W-1:0] r_req0_rdata;
  logic [DATA_W-1:0] r_req1_rdata;
  logic              r_req0_rvalid;
  logic              r_req1_rvalid;

  logic              w_sel;
  logic              w_acc;
  logic              w_acc_id;
  logic [CMD_W-1:0]  w_acc_cmd;
  logic [1:0]        w_op;
  logic              w_rd_done;
  logic              w_expire;

  // Tie goes to whoever was not granted last; a lone requester always wins.
  always_comb begin
    if (req0_valid && req1_valid) w_sel = ~r_last_grant;
    else                          w_sel = req1_valid;
  end

  assign w_acc     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign w_acc_id  = (r_state == c_st_idle) ? w_sel : r_owner;
  assign w_acc_cmd = w_acc_id ? req1_cmd : req0_cmd;
  assign w_op      = w_acc_cmd[CMD_W-1 -: 2];
  assign w_rd_done = (r_state == c_st_wait_rd) && ram_tx_valid;

  always_ff @(posedge clk) begin
    if (rst) r_state <= c_st_idle;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (w_expire) begin
      w_next_state = c_st_idle;
    end else if (w_acc) begin
      case (w_op)
        c_op_wr_addr: w_next_state = c_st_locked;
        c_op_rd_addr: w_next_state = c_st_locked;
        c_op_wr_data: w_next_state = c_st_idle;
        c_op_rd_data: w_next_state = c_st_wait_rd;
        default:      w_next_state = c_st_idle;
      endcase
    end else if (w_rd_done) begin
      w_next_state = c_st_idle;
    end
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (r_state)
      c_st_idle: begin
        req0_ready = req0_valid & ~w_sel;
        req1_ready = req1_valid &  w_sel;
      end
      c_st_locked: begin
        req0_ready = ~r_owner;
        req1_ready =  r_owner;
      end
      default: begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner        <= 1'b0;
      r_last_grant   <= 1'b1;
      r_ram_din      <= '0;
      r_ram_rx_valid <= 1'b0;
      r_req0_rdata   <= '0;
      r_req1_rdata   <= '0;
      r_req0_rvalid  <= 1'b0;
      r_req1_rvalid  <= 1'b0;
    end else begin
      r_ram_rx_valid <= w_acc;
      if (w_acc) r_ram_din <= w_acc_cmd;
      if (w_acc && (r_state == c_st_idle)) begin
        r_owner      <= w_sel;
        r_last_grant <= w_sel;
      end
      r_req0_rvalid <= w_rd_done & ~r_owner;
      r_req1_rvalid <= w_rd_done &  r_owner;
      if (w_rd_done && !r_owner) r_req0_rdata <= ram_dout;
      if (w_rd_done &&  r_owner) r_req1_rdata <= ram_dout;
    end
  end

`ifdef RAM_ARB_WATCHDOG_EN
  localparam logic [TMO_W-1:0] c_tmo_pre = TMO_W'((2 ** TMO_W) - 2);

  logic [TMO_W-1:0] r_tmo;
  logic             r_err;

  // Expiry fires on the edge where the count would reach its all-ones limit;
  // a real accept or RAM response in that same cycle takes precedence.
  assign w_expire = (r_state != c_st_idle) && (r_tmo == c_tmo_pre) && !w_acc && !w_rd_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_expire;
      if ((w_next_state != r_state) || w_acc) r_tmo <= '0;
      else if (r_state != c_st_idle)          r_tmo <= r_tmo + 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_expire = 1'b0;
  assign err      = 1'b0;
`endif

  assign ram_din      = r_ram_din;
  assign ram_rx_valid = r_ram_rx_valid;
  assign req0_rdata   = r_req0_rdata;
  assign req1_rdata   = r_req1_rdata;
  assign req0_rvalid  = r_req0_rvalid;
  assign req1_rvalid  = r_req1_rvalid;
  assign owner        = r_owner;
  assign busy         = (r_state != c_st_idle);

endmodule
`default_nettype wire
